// File: rtl/rect_mover_pkg.sv
// Shared types and mode encodings for the rectangle mover.
package rect_mover_pkg;

   localparam logic [1:0] MODE_BOUNCE = 2'd0;
   localparam logic [1:0] MODE_WRAP   = 2'd1;
   localparam logic [1:0] MODE_STOP   = 2'd2;

   typedef enum logic [1:0] {
      MOVE_POS,
      MOVE_NEG,
      HALTED
   } axis_state_t;

endpackage

// File: rtl/axis_mover.sv
// One animation axis: position, speed, direction/halt FSM and edge-hit pulse.
module axis_mover
   import rect_mover_pkg::*;
#(
   parameter int CW     = 12,
   parameter int SW     = 4,
   parameter int MIN    = 80,
   parameter int MAX    = 560,
   parameter int IP     = 320,
   parameter int IDIR   = 1,
   parameter int ISPEED = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   input  logic [1:0]    mode,
   input  logic          spd_load,
   input  logic [SW-1:0] spd_in,
   output logic [CW-1:0] pos,
   output logic          hit,
   output logic          hit_nxt,
   output axis_state_t   state_nxt
);

   localparam logic [CW-1:0] MIN_C = CW'(MIN);
   localparam logic [CW-1:0] MAX_C = CW'(MAX);
   localparam logic [CW:0]   MIN_W = (CW+1)'(MIN);
   localparam logic [CW:0]   MAX_W = (CW+1)'(MAX);

   // The fastest legal speed must not be able to jump across the whole range.
   if ((2**SW - 1) >= (MAX - MIN)) begin : g_bad_cfg
      $error("axis_mover: max speed must be smaller than MAX - MIN");
   end

   axis_state_t   state;
   logic [SW-1:0] speed;
   logic [CW:0]   cand_pos;
   logic [CW:0]   cand_neg;
   logic [CW-1:0] pos_nxt;

   // Next position/state/hit; a negative candidate shows up as the extra MSB set.
   always_comb begin
      cand_pos  = {1'b0, pos} + (CW+1)'(speed);
      cand_neg  = {1'b0, pos} - (CW+1)'(speed);
      pos_nxt   = pos;
      state_nxt = state;
      hit_nxt   = 1'b0;
      if (step && (speed != '0)) begin
         case (state)
            MOVE_POS: begin
               if (cand_pos >= MAX_W) begin
                  hit_nxt = 1'b1;
                  case (mode)
                     MODE_WRAP: pos_nxt = MIN_C;
                     MODE_STOP: begin
                        pos_nxt   = MAX_C;
                        state_nxt = HALTED;
                     end
                     default: begin
                        pos_nxt   = MAX_C;
                        state_nxt = MOVE_NEG;
                     end
                  endcase
               end else begin
                  pos_nxt = cand_pos[CW-1:0];
               end
            end
            MOVE_NEG: begin
               if (cand_neg[CW] || (cand_neg <= MIN_W)) begin
                  hit_nxt = 1'b1;
                  case (mode)
                     MODE_WRAP: pos_nxt = MAX_C;
                     MODE_STOP: begin
                        pos_nxt   = MIN_C;
                        state_nxt = HALTED;
                     end
                     default: begin
                        pos_nxt   = MIN_C;
                        state_nxt = MOVE_POS;
                     end
                  endcase
               end else begin
                  pos_nxt = cand_neg[CW-1:0];
               end
            end
            default: ;
         endcase
      end
      // A speed load re-arms a halted axis, heading away from the edge it rests on.
      if (spd_load && (state == HALTED))
         state_nxt = (pos >= MAX_C) ? MOVE_NEG : MOVE_POS;
   end

   // Axis registers; the speed load lands after any same-cycle step used the old speed.
   always_ff @(posedge clk) begin
      if (rst) begin
         pos   <= CW'(IP);
         state <= (IDIR != 0) ? MOVE_POS : MOVE_NEG;
         speed <= SW'(ISPEED);
         hit   <= 1'b0;
      end else begin
         pos   <= pos_nxt;
         state <= state_nxt;
         hit   <= hit_nxt;
         if (spd_load)
            speed <= spd_in;
      end
   end

endmodule

// File: rtl/rect_mover.sv
// Animated rectangle: two axis movers, bounce counter, moving flag, edge arithmetic.
module rect_mover
   import rect_mover_pkg::*;
#(
   parameter int CW       = 12,
   parameter int HALF_W   = 80,
   parameter int HALF_H   = 60,
   parameter int IX       = 320,
   parameter int IY       = 240,
   parameter int IX_DIR   = 1,
   parameter int IY_DIR   = 1,
   parameter int D_WIDTH  = 640,
   parameter int D_HEIGHT = 480,
   parameter int SW       = 4,
   parameter int ISPEED   = 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_ani_stb,
   input  logic          i_animate,
   input  logic [1:0]    i_mode,
   input  logic          i_spd_load,
   input  logic [SW-1:0] i_spd_x,
   input  logic [SW-1:0] i_spd_y,
   output logic [CW-1:0] o_x1,
   output logic [CW-1:0] o_x2,
   output logic [CW-1:0] o_y1,
   output logic [CW-1:0] o_y2,
   output logic          o_hit_x,
   output logic          o_hit_y,
   output logic [7:0]    o_bounces,
   output logic          o_moving
);

   logic          step;
   logic [CW-1:0] x;
   logic [CW-1:0] y;
   logic          hit_x_nxt;
   logic          hit_y_nxt;
   axis_state_t   x_state_nxt;
   axis_state_t   y_state_nxt;
   logic [8:0]    bounce_sum;

   assign step = i_animate && i_ani_stb;

   axis_mover #(
      .CW     (CW),
      .SW     (SW),
      .MIN    (HALF_W),
      .MAX    (D_WIDTH - HALF_W),
      .IP     (IX),
      .IDIR   (IX_DIR),
      .ISPEED (ISPEED)
   ) u_x (
      .clk       (i_clk),
      .rst       (i_rst),
      .step      (step),
      .mode      (i_mode),
      .spd_load  (i_spd_load),
      .spd_in    (i_spd_x),
      .pos       (x),
      .hit       (o_hit_x),
      .hit_nxt   (hit_x_nxt),
      .state_nxt (x_state_nxt)
   );

   axis_mover #(
      .CW     (CW),
      .SW     (SW),
      .MIN    (HALF_H),
      .MAX    (D_HEIGHT - HALF_H),
      .IP     (IY),
      .IDIR   (IY_DIR),
      .ISPEED (ISPEED)
   ) u_y (
      .clk       (i_clk),
      .rst       (i_rst),
      .step      (step),
      .mode      (i_mode),
      .spd_load  (i_spd_load),
      .spd_in    (i_spd_y),
      .pos       (y),
      .hit       (o_hit_y),
      .hit_nxt   (hit_y_nxt),
      .state_nxt (y_state_nxt)
   );

   assign o_x1 = x - CW'(HALF_W);
   assign o_x2 = x + CW'(HALF_W);
   assign o_y1 = y - CW'(HALF_H);
   assign o_y2 = y + CW'(HALF_H);

   // Widened sum so a double hit near the top still saturates cleanly.
   always_comb begin
      bounce_sum = {1'b0, o_bounces} + 9'(hit_x_nxt) + 9'(hit_y_nxt);
   end

   // Counter and moving flag track the axis next-state so they line up with the hit pulses.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_bounces <= '0;
         o_moving  <= 1'b1;
      end else begin
         o_bounces <= bounce_sum[8] ? 8'hFF : bounce_sum[7:0];
         o_moving  <= !((x_state_nxt == HALTED) && (y_state_nxt == HALTED));
      end
   end

endmodule
